// File: rtl/serial_subtractor.sv
// serial_subtractor: sequences WIDTH-bit operands LSB-first through an external
// full-subtractor cell, carrying the borrow between bits and collecting the result.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow_out,
   output logic             fs_minuend,
   output logic             fs_subtrahend,
   output logic             fs_carry_in,
   input  logic             fs_difference,
   input  logic             fs_borrow
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state;
   logic [WIDTH-1:0] r_a, r_b, r_r, r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_brw, r_bout, r_busy, r_done;
   logic [WIDTH-1:0] w_r_next;
   logic             w_shift;
   assign w_r_next      = {fs_difference, r_r[WIDTH-1:1]};
   assign w_shift       = (r_state == SHIFT);
   assign fs_minuend    = w_shift & r_a[0];
   assign fs_subtrahend = w_shift & r_b[0];
   assign fs_carry_in   = w_shift & r_brw;
   assign busy          = r_busy;
   assign done          = r_done;
   assign difference    = r_diff;
   assign borrow_out    = r_bout;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_r     <= '0;
         r_diff  <= '0;
         r_cnt   <= '0;
         r_brw   <= 1'b0;
         r_bout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_a     <= minuend;
               r_b     <= subtrahend;
               r_brw   <= 1'b0;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
               r_state <= SHIFT;
            end
            SHIFT: begin
               r_r   <= w_r_next;
               r_brw <= fs_borrow;
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_cnt <= r_cnt + 1'b1;
               // result and borrow are published only when the last bit lands
               if (r_cnt == LAST) begin
                  r_diff  <= w_r_next;
                  r_bout  <= fs_borrow;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random subtractions, checked by a scoreboard
// that pops expected {borrow, difference} whenever done pulses.
module tb_serial_subtractor;
   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [7:0] minuend, subtrahend, difference;
   logic       busy, done, borrow_out;
   logic       fs_minuend, fs_subtrahend, fs_carry_in, fs_difference, fs_borrow;
   logic [8:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         busy_cnt = 0;
   logic [7:0] cap;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .minuend(minuend), .subtrahend(subtrahend),
      .busy(busy), .done(done), .difference(difference), .borrow_out(borrow_out),
      .fs_minuend(fs_minuend), .fs_subtrahend(fs_subtrahend), .fs_carry_in(fs_carry_in),
      .fs_difference(fs_difference), .fs_borrow(fs_borrow)
   );

   // full-subtractor cell
   assign fs_difference = fs_minuend ^ fs_subtrahend ^ fs_carry_in;
   assign fs_borrow     = (~fs_minuend & fs_subtrahend) | (~(fs_minuend ^ fs_subtrahend) & fs_carry_in);

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      d = a - b;
      return {a < b, d};
   endfunction

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!done && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      start = 1'b1;
      minuend = a;
      subtrahend = b;
      exp_q.push_back(model(a, b));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b);
      issue(a, b);
      wait_done();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
               e = exp_q.pop_front();
               if ({borrow_out, difference} !== e) begin
                  errors++;
                  $display("FAIL result: got borrow=%0b diff=%0h expected borrow=%0b diff=%0h",
                           borrow_out, difference, e[8], e[7:0]);
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      minuend = 8'h00;
      subtrahend = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", difference, 0);
      chk("rst_borrow", borrow_out, 0);
      chk("rst_fs", {fs_minuend, fs_subtrahend, fs_carry_in}, 0);
      rst_n = 1'b1;
      // 0x5A - 0x23, busy for 9 cycles
      busy_cnt = 0;
      run_op(8'h5A, 8'h23);
      chk("busy_cycles", busy_cnt, 9);
      // 0x00 - 0x01, borrow propagates through bits 1..7
      issue(8'h00, 8'h01);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cap[i] = fs_carry_in;
      end
      chk("carry_in_bits", cap, 8'hFE);
      wait_done();
      @(posedge clk);
      #1;
      // 0x80 - 0x80, previous 0xFF held until done
      issue(8'h80, 8'h80);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("hold_prev", {borrow_out, difference}, 9'h1FF);
      end
      wait_done();
      @(posedge clk);
      #1;
      // start held high, operands changed mid-operation
      start = 1'b1;
      minuend = 8'h10;
      subtrahend = 8'h01;
      exp_q.push_back(model(8'h10, 8'h01));
      @(posedge clk);
      #1 minuend = 8'hFF;
      subtrahend = 8'h00;
      exp_q.push_back(model(8'hFF, 8'h00));
      wait_done();
      @(negedge clk);
      chk("idle_gap_busy", busy, 0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("second_accept_busy", busy, 1);
      wait_done();
      @(posedge clk);
      #1;
      // reset during bit 4 aborts the operation
      start = 1'b1;
      minuend = 8'h5A;
      subtrahend = 8'h23;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", difference, 0);
      chk("abort_borrow", borrow_out, 0);
      chk("abort_fs", {fs_minuend, fs_subtrahend, fs_carry_in}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h03, 8'h05);
      // random pairs on the earliest legal edge
      for (int i = 0; i < 1000; i++)
         run_op(8'($urandom), 8'($urandom));
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
